// File: rtl/mem_access_stage.sv
// Memory-access stage: turns aligned lw/sw ops into a single req/ack bus
// transaction, stalls upstream while the bus is busy, returns load data to
// write-back and reports misaligned addresses and bus timeouts.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        op_done,
  output logic        err_misaligned,
  output logic        err_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             w_accept;
  logic             w_misaligned;
  logic             w_ack_done;
  logic             w_timeout;

  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [4:0]       r_rd;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_op_done;
  logic             r_err_mis;
  logic             r_err_to;

  // Next-state and transition decode; op_valid only matters in IDLE and ack wins over timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_misaligned = 1'b0;
    w_ack_done   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          if (op_addr[1:0] == 2'b00) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_BUSY;
          end else begin
            w_misaligned = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_ack_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt >= CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; async reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Captured op, timeout counter, write-back data and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_op_done  <= 1'b0;
      r_err_mis  <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_op_done  <= 1'b0;
      r_err_mis  <= 1'b0;
      r_err_to   <= 1'b0;

      if (w_accept) begin
        r_we    <= op_write;
        r_addr  <= {op_addr[31:2], 2'b00};
        r_wdata <= op_wdata;
        r_rd    <= op_rd;
        r_cnt   <= '0;
      end

      if (w_misaligned) begin
        r_op_done <= 1'b1;
        r_err_mis <= 1'b1;
      end

      if ((r_state == ST_BUSY) && !w_ack_done && !w_timeout && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_ack_done) begin
        r_op_done <= 1'b1;
        r_we      <= 1'b0;
        if (!r_we) begin
          r_wb_data  <= mem_rdata;
          r_wb_rd    <= r_rd;
          r_wb_valid <= (r_rd != 5'd0);
        end
      end

      if (w_timeout) begin
        r_op_done <= 1'b1;
        r_err_to  <= 1'b1;
        r_we      <= 1'b0;
      end
    end
  end

  assign stall          = (r_state == ST_BUSY);
  assign mem_req        = (r_state == ST_BUSY);
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign wb_valid       = r_wb_valid;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign op_done        = r_op_done;
  assign err_misaligned = r_err_mis;
  assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT_CYCLES=4.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_write;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [4:0]  op_rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_done;
  logic        err_misaligned;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_write(op_write), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_done(op_done), .err_misaligned(err_misaligned), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd);
    op_valid = 1'b1;
    op_write = wr;
    op_addr  = addr;
    op_wdata = wd;
    op_rd    = rd;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_write = 1'b0; op_addr = '0; op_wdata = '0;
    op_rd = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_pulses", {28'd0, wb_valid, op_done, err_misaligned, err_timeout}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait load
    present(1'b0, 32'h0000_0010, 32'h0, 5'd5);
    tick();
    op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("zw_mem_req", 32'(mem_req), 32'd1);
    chk("zw_stall", 32'(stall), 32'd1);
    chk("zw_mem_addr", mem_addr, 32'h10);
    chk("zw_mem_we", 32'(mem_we), 32'd0);
    chk("zw_done_early", 32'(op_done), 32'd0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("zw_wb_valid", 32'(wb_valid), 32'd1);
    chk("zw_wb_rd", 32'(wb_rd), 32'd5);
    chk("zw_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("zw_op_done", 32'(op_done), 32'd1);
    chk("zw_stall_off", 32'(stall), 32'd0);
    chk("zw_req_off", 32'(mem_req), 32'd0);
    tick();
    chk("zw_pulse_width", {30'd0, wb_valid, op_done}, 32'd0);

    // Wait-state store, ack in 3rd BUSY cycle
    present(1'b1, 32'h0000_0020, 32'h1234_5678, 5'd0);
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("st_mem_req", 32'(mem_req), 32'd1);
      chk("st_mem_we", 32'(mem_we), 32'd1);
      chk("st_mem_addr", mem_addr, 32'h20);
      chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
      chk("st_stall", 32'(stall), 32'd1);
      chk("st_no_done", 32'(op_done), 32'd0);
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("st_op_done", 32'(op_done), 32'd1);
    chk("st_wb_valid", 32'(wb_valid), 32'd0);
    chk("st_stall_off", 32'(stall), 32'd0);
    chk("st_we_off", 32'(mem_we), 32'd0);
    tick();

    // Misaligned: back-to-back every cycle, no bus access, no stall
    present(1'b0, 32'h0000_0013, 32'h0, 5'd3);
    tick();
    chk("mis_err", 32'(err_misaligned), 32'd1);
    chk("mis_done", 32'(op_done), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    op_addr = 32'h0000_0016;
    tick();
    op_valid = 1'b0;
    chk("mis2_err", 32'(err_misaligned), 32'd1);
    chk("mis2_req", 32'(mem_req), 32'd0);
    chk("mis2_wb", 32'(wb_valid), 32'd0);
    tick();
    chk("mis_err_off", 32'(err_misaligned), 32'd0);
    chk("mis_done_off", 32'(op_done), 32'd0);

    // Timeout with ack held low: req high exactly 4 cycles
    present(1'b0, 32'h0000_0040, 32'h0, 5'd7);
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(mem_req), 32'd1);
      chk("to_no_err", 32'(err_timeout), 32'd0);
      tick();
    end
    chk("to_req_off", 32'(mem_req), 32'd0);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_done", 32'(op_done), 32'd1);
    chk("to_wb", 32'(wb_valid), 32'd0);
    tick();
    chk("to_err_off", 32'(err_timeout), 32'd0);

    // Ack in the 4th BUSY cycle beats the timeout
    present(1'b0, 32'h0000_0044, 32'h0, 5'd8);
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("race_req", 32'(mem_req), 32'd1);
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
      tick();
    end
    mem_ack = 1'b0;
    chk("race_no_err", 32'(err_timeout), 32'd0);
    chk("race_done", 32'(op_done), 32'd1);
    chk("race_wb_valid", 32'(wb_valid), 32'd1);
    chk("race_wb_data", wb_data, 32'hCAFE_F00D);
    chk("race_wb_rd", 32'(wb_rd), 32'd8);
    tick();

    // Load to $0: bus read happens, no writeback
    present(1'b0, 32'h0000_0050, 32'h0, 5'd0);
    tick();
    op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    chk("r0_req", 32'(mem_req), 32'd1);
    chk("r0_addr", mem_addr, 32'h50);
    tick();
    mem_ack = 1'b0;
    chk("r0_done", 32'(op_done), 32'd1);
    chk("r0_wb_valid", 32'(wb_valid), 32'd0);
    tick();

    // Reset in the 2nd BUSY cycle
    present(1'b0, 32'h0000_0060, 32'h0, 5'd9);
    tick();
    op_valid = 1'b0;
    tick();
    chk("rb_req_before", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rb_req_async", 32'(mem_req), 32'd0);
    chk("rb_stall_async", 32'(stall), 32'd0);
    tick();
    chk("rb_pulses", {28'd0, wb_valid, op_done, err_misaligned, err_timeout}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rb_post_pulses", {28'd0, wb_valid, op_done, err_misaligned, err_timeout}, 32'd0);
    chk("rb_post_req", 32'(mem_req), 32'd0);

    // New load after reset completes normally
    present(1'b0, 32'h0000_0070, 32'h0, 5'd2);
    tick();
    op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    chk("ar_req", 32'(mem_req), 32'd1);
    chk("ar_addr", mem_addr, 32'h70);
    tick();
    mem_ack = 1'b0;
    chk("ar_wb_valid", 32'(wb_valid), 32'd1);
    chk("ar_wb_rd", 32'(wb_rd), 32'd2);
    chk("ar_wb_data", wb_data, 32'hA5A5_5A5A);
    chk("ar_done", 32'(op_done), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
